fetch_ctrl: RTL
===============

Name: fetch_ctrl

Overview:
- Sequencer for the instruction-fetch stage.
- Owns the PC register and drives a multi-cycle instruction memory (stalling-memory handshake: rd / done / stall).
- Buffers the returned instruction until decode accepts it; applies branch/jump redirects, pipeline stalls and halt.
- Sits between the hazard/branch-resolution logic and the instruction memory; feeds the IF/ID pipeline register.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- NOP_INSTR, 16'h0800, encoding presented on instr_out whenever instr_valid is low.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  decode cannot accept an instruction this cycle.
- redirect  in  1  taken branch/jump/JR resolved; discard in-flight fetch.
- redirect_pc  in  16  new PC; sampled when redirect=1.
- halt  in  1  HALT decoded; stop fetching.
- mem_done  in  1  instruction memory data valid this cycle.
- mem_stall  in  1  instruction memory busy; cannot accept a request.
- mem_data  in  16  instruction memory read data.
- mem_rd  out  1  read request.
- mem_addr  out  16  read address; equals current PC.
- instr_out  out  16  instruction to IF/ID.
- pc_inc_out  out  16  fetched PC + 2, to IF/ID.
- instr_valid  out  1  instr_out/pc_inc_out are a real instruction.
- stall_cycles  out  16  performance counter (see Optional Feature).

Behaviour:
- Reset: PC = RESET_PC, state = ISSUE, mem_rd = 0, instr_valid = 0, instr_out = NOP_INSTR, pc_inc_out = 0, discard = 0, stall_cycles = 0.
- Reset mid-operation drops any outstanding request, buffered instruction and discard flag, with no residue.
- ISSUE:
  - Assert mem_rd, mem_addr = PC, provided mem_stall = 0.
  - mem_done in the same cycle (hit, 0-wait) -> capture into buffer, go to HOLD.
  - Otherwise -> WAIT.
- WAIT:
  - mem_rd = 0; mem_addr is held at PC.
  - On mem_done with discard = 0 -> capture, go to HOLD.
  - On mem_done with discard = 1 -> drop data, clear discard, go to ISSUE.
- HOLD:
  - instr_valid = 1, instr_out = buffer, pc_inc_out = PC + 2.
  - If stall = 0 -> PC <= PC + 2, go to ISSUE. Consumption costs one cycle; there is no overlapped prefetch.
  - If stall = 1 -> remain; outputs are held stable.
- HALTED:
  - mem_rd = 0, instr_valid = 0.
  - Leave only on reset, or on redirect (an older instruction killing the halt).
- Redirect, any state:
  - PC <= redirect_pc; buffer invalidated; instr_valid = 0 next cycle.
  - In WAIT: set discard and stay in WAIT. The outstanding read must complete before a new one is issued.
  - In ISSUE with request accepted but no mem_done: as in WAIT.
  - Otherwise go to ISSUE.
- Priority: rst > redirect > halt > stall.
  - Simultaneous redirect + halt -> redirect wins.
  - halt in WAIT -> go to HALTED after mem_done, data dropped.
  - halt otherwise -> HALTED next cycle.
- Arithmetic: PC + 2 is 16-bit and wraps (16'hFFFE -> 16'h0000); no overflow flag.
- mem_rd never asserts while mem_stall = 1 or while a request is outstanding.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- Defined: stall_cycles increments by 1 every cycle in WAIT, or in HOLD with stall = 1. It saturates at 16'hFFFF and resets to 0.
- Undefined: stall_cycles is tied to 16'h0000; no counter flops are synthesized.

Decomposition:
- Shared package/include: state encodings (ISSUE, WAIT, HOLD, HALTED, 2 bits), NOP_INSTR, RESET_PC.
- Sub-module: fetch_ctrl_fsm (next-state and control decode only).
- PC, buffer and counter registers remain in fetch_ctrl, built from the team's dff cells; the PC + 2 adder is the existing cla16.

Test Plan:
- Reset then release, 0-wait memory (mem_done with rd) -> mem_addr sequence 0000, 0002, 0004; instr_valid every 2nd cycle; pc_inc_out 0002, 0004.
- 3-cycle memory latency, mem_data 16'hC123 -> one mem_rd pulse; instr_valid rises the cycle after mem_done; instr_out = C123.
- Redirect to 16'h0040 during WAIT -> returning data dropped (instr_valid stays 0); next mem_rd has mem_addr = 0040.
- stall held 5 cycles in HOLD -> instr_out/pc_inc_out stable, no mem_rd. With FETCH_PERF_CNT_EN, stall_cycles increases by 5.
- halt and redirect (0x0010) in same cycle -> no HALTED, fetch resumes at 0010. halt alone -> mem_rd stays 0 for 20 cycles.
- PC = FFFE, fetch consumed -> next mem_addr = 0000. rst asserted in WAIT -> next cycle mem_addr = 0000, instr_valid = 0, and a late mem_done is ignored.

Source files
------------

// File: rtl/fetch_ctrl_pkg.sv
// Shared definitions for the instruction-fetch sequencer: state encodings,
// default reset PC / NOP encoding and a saturating-increment helper.
package fetch_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_ISSUE  = 2'b00,
        ST_WAIT   = 2'b01,
        ST_HOLD   = 2'b10,
        ST_HALTED = 2'b11
    } fetch_state_e;

    localparam logic [15:0] RESET_PC_DEF  = 16'h0000;
    localparam logic [15:0] NOP_INSTR_DEF = 16'h0800;

    // Increment that sticks at all-ones instead of wrapping
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        if (v == 16'hFFFF) begin
            return v;
        end else begin
            return v + 16'h0001;
        end
    endfunction

endpackage

// File: rtl/cla16.sv
// 16-bit carry-lookahead adder: four 4-bit lookahead groups, group carries chained.
module cla16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] sum,
    output logic        cout
);

    logic [15:0] g;
    logic [15:0] p;
    logic [15:0] carry;

    assign g = a & b;
    assign p = a ^ b;

    // Lookahead carries within each group, group carry-out feeds the next group
    always_comb begin
        logic       grp_c;
        logic [3:0] gp;
        logic [3:0] gg;
        carry = 16'h0000;
        grp_c = cin;
        for (int k = 0; k < 4; k++) begin
            gp = p[4*k +: 4];
            gg = g[4*k +: 4];
            carry[4*k]   = grp_c;
            carry[4*k+1] = gg[0] | (gp[0] & grp_c);
            carry[4*k+2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & grp_c);
            carry[4*k+3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
                         | (gp[2] & gp[1] & gp[0] & grp_c);
            grp_c        = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
                         | (gp[3] & gp[2] & gp[1] & gg[0]) | ((&gp) & grp_c);
        end
        cout = grp_c;
    end

    assign sum = p ^ carry;

endmodule

// File: rtl/dff.sv
// Generic register cell: synchronous active-high reset to RST_VAL, load enable.
module dff #(
    parameter int           W       = 1,
    parameter logic [W-1:0] RST_VAL = {W{1'b0}}
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // Storage with synchronous reset and load enable
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= RST_VAL;
        end else if (en) begin
            q <= d;
        end else begin
            q <= q;
        end
    end

endmodule

// File: rtl/fetch_ctrl_fsm.sv
// Fetch sequencer state machine: owns the state register and decodes the
// control strobes (read request, capture, PC load, discard/halt bookkeeping).
module fetch_ctrl_fsm
    import fetch_ctrl_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic redirect,
    input  logic halt,
    input  logic stall,
    input  logic mem_stall,
    input  logic mem_done,
    input  logic discard,
    input  logic halt_pend,
    output logic mem_rd,
    output logic capture,
    output logic pc_redirect,
    output logic pc_advance,
    output logic discard_nxt,
    output logic halt_pend_nxt,
    output logic instr_valid,
    output logic stall_event
);

    fetch_state_e state;
    fetch_state_e state_nxt;
    logic         rd_ok;

    // A request may go out only when memory is free; halt and reset suppress it
    assign rd_ok = !rst && !mem_stall && !halt;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_ISSUE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and control decode; redirect outranks halt, halt outranks stall
    always_comb begin
        state_nxt     = state;
        mem_rd        = 1'b0;
        capture       = 1'b0;
        pc_redirect   = 1'b0;
        pc_advance    = 1'b0;
        discard_nxt   = discard;
        halt_pend_nxt = halt_pend;
        instr_valid   = 1'b0;
        stall_event   = 1'b0;
        case (state)
            ST_ISSUE: begin
                mem_rd = rd_ok;
                if (redirect) begin
                    pc_redirect = 1'b1;
                    if (rd_ok && !mem_done) begin
                        // read already accepted: it must drain before refetching
                        discard_nxt = 1'b1;
                        state_nxt   = ST_WAIT;
                    end else begin
                        state_nxt = ST_ISSUE;
                    end
                end else if (halt) begin
                    state_nxt = ST_HALTED;
                end else if (rd_ok && mem_done) begin
                    capture   = 1'b1;
                    state_nxt = ST_HOLD;
                end else if (rd_ok) begin
                    state_nxt = ST_WAIT;
                end else begin
                    state_nxt = ST_ISSUE;
                end
            end
            ST_WAIT: begin
                stall_event = 1'b1;
                if (redirect) begin
                    pc_redirect   = 1'b1;
                    halt_pend_nxt = 1'b0;
                    if (mem_done) begin
                        discard_nxt = 1'b0;
                        state_nxt   = ST_ISSUE;
                    end else begin
                        discard_nxt = 1'b1;
                        state_nxt   = ST_WAIT;
                    end
                end else if (mem_done) begin
                    discard_nxt   = 1'b0;
                    halt_pend_nxt = 1'b0;
                    if (halt || halt_pend) begin
                        state_nxt = ST_HALTED;
                    end else if (discard) begin
                        state_nxt = ST_ISSUE;
                    end else begin
                        capture   = 1'b1;
                        state_nxt = ST_HOLD;
                    end
                end else if (halt) begin
                    halt_pend_nxt = 1'b1;
                    state_nxt     = ST_WAIT;
                end else begin
                    state_nxt = ST_WAIT;
                end
            end
            ST_HOLD: begin
                instr_valid = 1'b1;
                if (redirect) begin
                    pc_redirect = 1'b1;
                    instr_valid = 1'b1;
                    state_nxt   = ST_ISSUE;
                end else if (halt) begin
                    state_nxt = ST_HALTED;
                end else if (!stall) begin
                    pc_advance = 1'b1;
                    state_nxt  = ST_ISSUE;
                end else begin
                    stall_event = 1'b1;
                    state_nxt   = ST_HOLD;
                end
            end
            ST_HALTED: begin
                if (redirect) begin
                    pc_redirect = 1'b1;
                    state_nxt   = ST_ISSUE;
                end else begin
                    state_nxt = ST_HALTED;
                end
            end
            default: begin
                state_nxt = ST_ISSUE;
            end
        endcase
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer top: PC, instruction buffer and flag registers,
// PC + 2 adder and output muxing around fetch_ctrl_fsm.
// Optional stall-cycle performance counter enabled by defining FETCH_PERF_CNT_EN.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter logic [15:0] RESET_PC  = RESET_PC_DEF,
    parameter logic [15:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    input  logic        halt,
    input  logic        mem_done,
    input  logic        mem_stall,
    input  logic [15:0] mem_data,
    output logic        mem_rd,
    output logic [15:0] mem_addr,
    output logic [15:0] instr_out,
    output logic [15:0] pc_inc_out,
    output logic        instr_valid,
    output logic [15:0] stall_cycles
);

    logic [15:0] pc;
    logic [15:0] pc_plus2;
    logic [15:0] pc_d;
    logic [15:0] instr_buf;
    logic        discard;
    logic        halt_pend;
    logic        capture;
    logic        pc_redirect;
    logic        pc_advance;
    logic        discard_nxt;
    logic        halt_pend_nxt;
    logic        stall_event;
    logic        unused_carry;

    fetch_ctrl_fsm u_fsm (
        .clk           (clk),
        .rst           (rst),
        .redirect      (redirect),
        .halt          (halt),
        .stall         (stall),
        .mem_stall     (mem_stall),
        .mem_done      (mem_done),
        .discard       (discard),
        .halt_pend     (halt_pend),
        .mem_rd        (mem_rd),
        .capture       (capture),
        .pc_redirect   (pc_redirect),
        .pc_advance    (pc_advance),
        .discard_nxt   (discard_nxt),
        .halt_pend_nxt (halt_pend_nxt),
        .instr_valid   (instr_valid),
        .stall_event   (stall_event)
    );

    // PC + 2 wraps naturally at 16 bits; the carry-out is not needed
    cla16 u_pc_add (
        .a    (pc),
        .b    (16'h0002),
        .cin  (1'b0),
        .sum  (pc_plus2),
        .cout (unused_carry)
    );

    assign pc_d = pc_redirect ? redirect_pc : pc_plus2;

    dff #(.W(16), .RST_VAL(RESET_PC)) u_pc (
        .clk (clk), .rst (rst), .en (pc_redirect | pc_advance), .d (pc_d), .q (pc)
    );

    dff #(.W(16), .RST_VAL(NOP_INSTR)) u_buf (
        .clk (clk), .rst (rst), .en (capture), .d (mem_data), .q (instr_buf)
    );

    dff #(.W(1), .RST_VAL(1'b0)) u_discard (
        .clk (clk), .rst (rst), .en (1'b1), .d (discard_nxt), .q (discard)
    );

    dff #(.W(1), .RST_VAL(1'b0)) u_halt_pend (
        .clk (clk), .rst (rst), .en (1'b1), .d (halt_pend_nxt), .q (halt_pend)
    );

    assign mem_addr   = pc;
    assign instr_out  = instr_valid ? instr_buf : NOP_INSTR;
    assign pc_inc_out = instr_valid ? pc_plus2 : 16'h0000;

`ifdef FETCH_PERF_CNT_EN
    logic [15:0] cnt_q;

    dff #(.W(16), .RST_VAL(16'h0000)) u_cnt (
        .clk (clk), .rst (rst), .en (stall_event), .d (sat_inc16(cnt_q)), .q (cnt_q)
    );

    assign stall_cycles = cnt_q;
`else
    logic unused_stall_event;

    assign unused_stall_event = stall_event;
    assign stall_cycles       = 16'h0000;
`endif

endmodule
